// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq: operand sequencer / result collector around an
// external combinational 4-bit ripple-carry adder. Operands are fed one nibble
// per cycle, LSB nibble first, with the carry chained through carry_q.
// Optional macro SUB_EN adds a 'sub' port for modular subtraction.
module nibble_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_cout
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
    $error("nibble_serial_add_seq: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               result_cout_q, result_cout_d;

  logic [IDX_W+1:0]   nib_base;
  logic               last_nib;
  logic               accept;
  logic [WIDTH-1:0]   b_load;
  logic               c_load;

  assign nib_base = {idx_q, 2'b00};
  assign last_nib = (idx_q == IDX_W'(NIB - 1));
  assign accept   = (state_q == IDLE) && in_valid;

  // Operand B and first carry as loaded; subtraction becomes a + ~b + 1.
  always_comb begin
    b_load = op_b;
    c_load = cin;
`ifdef SUB_EN
    if (sub) begin
      b_load = ~op_b;
      c_load = 1'b1;
    end
`endif
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      result_q      <= '0;
      result_cout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      carry_q       <= carry_d;
      a_q           <= a_d;
      b_q           <= b_d;
      result_q      <= result_d;
      result_cout_q <= result_cout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand load on accept, nibble collection in RUN.
  always_comb begin
    idx_d         = idx_q;
    carry_d       = carry_q;
    a_d           = a_q;
    b_d           = b_q;
    result_d      = result_q;
    result_cout_d = result_cout_q;
    if (accept) begin
      a_d     = op_a;
      b_d     = b_load;
      carry_d = c_load;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      result_d[nib_base +: 4] = add_sum;
      carry_d                 = add_cout;
      if (last_nib) begin
        idx_d         = '0;
        result_cout_d = add_cout;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Outputs: adder drive is zero outside RUN; handshakes follow the state.
  always_comb begin
    add_a       = '0;
    add_b       = '0;
    add_c       = 1'b0;
    if (state_q == RUN) begin
      add_a = a_q[nib_base +: 4];
      add_b = b_q[nib_base +: 4];
      add_c = carry_q;
    end
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    result      = result_q;
    result_cout = result_cout_q;
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Bench for nibble_serial_add_seq (WIDTH=16) with a behavioural 4-bit adder.
module tb_nibble_serial_add_seq;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [15:0] op_a, op_b;
  logic        cin;
  logic        sub_r;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_c, add_cout;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        result_cout;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  nibble_serial_add_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SUB_EN
    .sub(sub_r),
`endif
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_cout(result_cout)
  );

  // behavioural external adder
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever a result is handed over
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got 0x%0h with none expected", {result_cout, result});
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({result_cout, result} !== e) begin
          errors++;
          $display("FAIL result: got cout=%0d sum=0x%04h expected cout=%0d sum=0x%04h",
                   result_cout, result, e[16], e[15:0]);
        end
      end
    end
  end

  // present one operand set, returns once the accept edge has passed
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic s, input logic [15:0] er, input logic ec);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; cin = c; sub_r = s;
    @(posedge clk);
    exp_q.push_back({ec, er});
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] a_seq[4];
    int n;
    bit ov_seen;
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    sub_r = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'({result_cout, result}), 32'd0);
    chk("reset_add_a", 32'(add_a), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 1: latency and nibble order
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    n = 0;
    ov_seen = 0;
    for (int i = 1; i <= 10 && !ov_seen; i++) begin
      @(negedge clk);
      if (i <= 4) a_seq[i-1] = add_a;
      if (out_valid) begin
        n = i;
        ov_seen = 1;
      end
    end
    chk("latency", 32'(n), 32'd5);
    chk("add_a_seq", {16'd0, a_seq[0], a_seq[1], a_seq[2], a_seq[3]}, 32'h4321);
    drain();

    // 2: carry ripples through every nibble
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    chk("ripple_c0", 32'(add_c), 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("ripple_c", 32'(add_c), 32'd1);
    end
    drain();

    // 3: carry-in only, and carry-in with overflow
    issue(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);
    issue(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1);
    drain();

    // 4: backpressure with in_valid held and operands changing
    out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0);
    wait_valid();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op_a = 16'(i * 16'h0101); op_b = 16'(16'hF0F0 - i);
      @(negedge clk);
      chk("bp_result", 32'(result), 32'h3333);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    op_a = 16'h0A0A; op_b = 16'h0505; cin = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back({1'b0, 16'h0F0F});
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(in_ready), 32'd0);
    drain();

    // 5: asynchronous reset mid-RUN aborts the operation
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0);
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'({result_cout, result}), 32'd0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1;
    end
    chk("abort_no_out_valid", 32'(ov_seen), 32'd0);
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0);
    drain();

`ifdef SUB_EN
    // 6: subtraction, borrow and no-borrow
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    issue(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
